// File: rtl/iic_pkg.sv
// Shared definitions for the I2C register target: FSM states and bus bit values.
package iic_pkg;

  // One state per protocol phase; ACK states cover the 9th clock of each byte.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } iic_state_e;

  // Level on SDA during the 9th clock of a byte.
  localparam logic IIC_ACK  = 1'b0;
  localparam logic IIC_NACK = 1'b1;

  // Bits per byte on the bus.
  localparam logic [3:0] IIC_BITS = 4'd8;

endpackage

// File: rtl/iic_line_sync.sv
// Brings SCL/SDA into the clk domain and decodes SCL edges, START and STOP.
// Each line runs through two synchronizer flops plus one delay flop, so an
// event is visible combinationally two clocks after the pin change.
module iic_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync stage, [1] synchronized sample, [2] delayed sample
  logic [2:0] scl_q, scl_d;
  logic [2:0] sda_q, sda_d;

  // Shift each pin into its three-stage pipeline.
  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end

  // Pipeline flops reset to the idle-bus level so reset release creates no event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  // SDA may only move while SCL is low; a move while SCL stays high is a condition.
  assign start_det =  scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target exposing NREGS 8-bit control registers. The first write byte
// after the address loads the register pointer; further bytes write through
// it with auto-increment. Reads stream registers from the pointer onward.
module iic_slave_regs
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2C,
  parameter int         NREGS    = 4,
  parameter int         PTR_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe,
  output logic [8*NREGS-1:0] regs,
  output logic               wr_stb,
  output logic [PTR_W-1:0]   wr_idx,
  output logic               busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  iic_state_e       state_q,   state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic [PTR_W-1:0] ptr_q,     ptr_d;
  logic [7:0]       regs_q [NREGS];
  logic [7:0]       regs_d [NREGS];
  logic             sda_oe_q,  sda_oe_d;
  logic             wr_stb_q,  wr_stb_d;
  logic [PTR_W-1:0] wr_idx_q,  wr_idx_d;
  logic             busy_q,    busy_d;
  logic             rw_q,      rw_d;
  // Set once the ACK has been driven, so the following fall ends the ACK slot.
  logic             ack_drv_q, ack_drv_d;

  // Next-state, shifter, pointer and register-bank update for one clk.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    ack_drv_d = ack_drv_q;

    if (stop_det) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
    end else if (start_det) begin
      // START outranks an SCL fall decoded in the same clk.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      ack_drv_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            // NOTE: blocking assignments in always_comb, so shift_d below
            // already holds the byte including this bit.
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_d == IIC_BITS) begin
              bit_cnt_d = 4'd0;
              ack_drv_d = 1'b0;
              if (state_q == ST_ADDR) begin
                if (shift_d[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = shift_d[0];
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = shift_d[PTR_W-1:0];
                state_d = ST_REG_ACK;
              end else begin
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end

        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_d  = ~IIC_ACK;
              ack_drv_d = 1'b1;
              // A data byte commits only here, so an aborted byte never lands.
              if (state_q == ST_WDATA_ACK) begin
                regs_d[ptr_q] = shift_q;
                wr_stb_d      = 1'b1;
                wr_idx_d      = ptr_q;
                ptr_d         = ptr_q + PTR_W'(1);
              end
            end else begin
              sda_oe_d  = 1'b0;
              ack_drv_d = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                // First read byte: load and drive its MSB on this same fall.
                state_d  = ST_RDATA;
                shift_d  = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              // Fall after the master's ACK starts the next byte.
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else if (bit_cnt_q == IIC_BITS) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == IIC_NACK) begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end else begin
              ptr_d     = ptr_q + PTR_W'(1);
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA;
            end
          end
        end

        ST_IGNORE: sda_oe_d = 1'b0;

        default: ;
      endcase
    end
  end

  // State and output flops; everything returns to its reset value at once on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      ack_drv_q <= 1'b0;
      // NOTE: the register bank is reset like any other flop because its
      // contents are visible outputs with a defined reset value.
      for (int k = 0; k < NREGS; k++) regs_q[k] <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      ack_drv_q <= ack_drv_d;
      regs_q    <= regs_d;
    end
  end

  // Flatten the bank onto the output bus, register k at [8k+7:8k].
  always_comb begin
    regs = '0;
    for (int k = 0; k < NREGS; k++) regs[8*k +: 8] = regs_q[k];
  end

  assign sda_oe = sda_oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule
